fly_hit_scanner: RTL and testbench

- Sits directly downstream of the fly enemy controller and consumes its flattened fly position and alive buses.
- Once per frame, scans all flies sequentially against the player bullet's bounding box.
- Reports at most one hit per scan, with the fly index, to the controller through a valid/ack handshake. Also consumes the bullet and keeps a saturating score.

---
 rtl/fly_hit_scanner_if.sv | 29 ++
 rtl/fly_hit_scanner.sv | 143 ++++++++++++++
 tb/tb_fly_hit_scanner.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fly_hit_scanner_if.sv
// ---------------------------------------------------------------------------
// fly_hit_scanner_if
//   Hit report handshake between the fly hit scanner and the fly enemy
//   controller.
//   hit_valid      : scanner -> controller, a hit is pending
//   hit_idx        : scanner -> controller, index of the hit fly
//   hit_ack        : controller -> scanner, fly hit_idx has been killed
//   bullet_consume : scanner -> controller, one-cycle pulse, retire bullet
// ---------------------------------------------------------------------------
interface fly_hit_scanner_if;
    logic       hit_valid;
    logic [4:0] hit_idx;
    logic       hit_ack;
    logic       bullet_consume;

    modport master (
        output hit_valid,
        output hit_idx,
        output bullet_consume,
        input  hit_ack
    );

    modport slave (
        input  hit_valid,
        input  hit_idx,
        input  bullet_consume,
        output hit_ack
    );
endinterface

// File: rtl/fly_hit_scanner.sv
// ---------------------------------------------------------------------------
// fly_hit_scanner
//   Once per frame, walks the fly slots one per clock and compares each live
//   fly against the bullet box latched at frame start. The first (lowest
//   index) overlap is reported through the hit handshake; on acknowledge the
//   bullet is retired and a saturating score is bumped.
//
//   clk25          : pixel clock, all state changes on rising edge
//   reset_n        : asynchronous active-low reset
//   frame_tick     : one-cycle frame pulse, starts a scan from IDLE
//   fly_x_flat     : fly i x at [i*10 +: 10]
//   fly_y_flat     : fly i y at [i*10 +: 10]
//   fly_alive_flat : fly i alive at bit i
//   bullet_x/y     : bullet top-left corner
//   bullet_active  : bullet is in flight
//   hit            : hit report handshake (master side)
//   scan_done      : one-cycle pulse at the end of every scan
//   score          : acknowledged hits, saturating at SCORE_MAX
//   scan_overrun   : sticky, frame_tick seen while not IDLE
// ---------------------------------------------------------------------------
module fly_hit_scanner #(
    parameter int N_FLY     = 17,
    parameter int FLY_W     = 32,
    parameter int FLY_H     = 32,
    parameter int BUL_W     = 2,
    parameter int BUL_H     = 8,
    parameter int SCORE_MAX = 9999
) (
    input  logic                  clk25,
    input  logic                  reset_n,
    input  logic                  frame_tick,
    input  logic [10*N_FLY-1:0]   fly_x_flat,
    input  logic [10*N_FLY-1:0]   fly_y_flat,
    input  logic [N_FLY-1:0]      fly_alive_flat,
    input  logic [9:0]            bullet_x,
    input  logic [9:0]            bullet_y,
    input  logic                  bullet_active,
    fly_hit_scanner_if.master     hit,
    output logic                  scan_done,
    output logic [13:0]           score,
    output logic                  scan_overrun
);

    typedef enum logic [1:0] {IDLE, SCAN, REPORT, DONE} state_t;

    state_t     state, state_nxt;
    logic [4:0] idx;
    logic [9:0] bx, by;
    logic [9:0] fx, fy;
    logic       alive;
    logic       hit_now;

    // Current fly selected by idx. Constant part-selects in a loop keep the
    // mux free of out-of-range reads.
    // NOTE: every combinational output gets a default first so that no path
    // leaves a value unassigned, which would otherwise infer a latch.
    always_comb begin
        fx    = '0;
        fy    = '0;
        alive = 1'b0;
        for (int i = 0; i < N_FLY; i++) begin
            if (idx == 5'(i)) begin
                fx    = fly_x_flat[i*10 +: 10];
                fy    = fly_y_flat[i*10 +: 10];
                alive = fly_alive_flat[i];
            end
        end
    end

    // Box overlap on 11-bit sums so fx+FLY_W near the screen edge cannot wrap.
    always_comb begin
        hit_now = alive
               && ({1'b0, bx} < ({1'b0, fx} + 11'(FLY_W)))
               && ({1'b0, fx} < ({1'b0, bx} + 11'(BUL_W)))
               && ({1'b0, by} < ({1'b0, fy} + 11'(FLY_H)))
               && ({1'b0, fy} < ({1'b0, by} + 11'(BUL_H)));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_tick) state_nxt = bullet_active ? SCAN : DONE;
            SCAN: begin
                if (hit_now)                     state_nxt = REPORT;
                else if (idx == 5'(N_FLY - 1))   state_nxt = DONE;
            end
            REPORT:  if (hit.hit_ack) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            idx                <= '0;
            bx                 <= '0;
            by                 <= '0;
            hit.hit_valid      <= 1'b0;
            hit.hit_idx        <= '0;
            hit.bullet_consume <= 1'b0;
            scan_done          <= 1'b0;
            score              <= '0;
            scan_overrun       <= 1'b0;
        end else begin
            state              <= state_nxt;
            hit.bullet_consume <= 1'b0;
            // scan_done trails the DONE state by one cycle.
            scan_done          <= (state == DONE);

            if (frame_tick && state != IDLE) scan_overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (frame_tick && bullet_active) begin
                        bx  <= bullet_x;
                        by  <= bullet_y;
                        idx <= '0;
                    end
                end
                SCAN: begin
                    if (hit_now) begin
                        hit.hit_valid <= 1'b1;
                        hit.hit_idx   <= idx;
                    end else begin
                        idx <= idx + 5'd1;
                    end
                end
                REPORT: begin
                    if (hit.hit_ack) begin
                        hit.hit_valid      <= 1'b0;
                        hit.bullet_consume <= 1'b1;
                        if (score < 14'(SCORE_MAX)) score <= score + 14'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fly_hit_scanner.sv
// ---------------------------------------------------------------------------
// tb_fly_hit_scanner
//   Directed bench for fly_hit_scanner. Outputs are sampled 1 ns after the
//   rising edge; "cycle T" is the cycle whose closing edge samples frame_tick.
// ---------------------------------------------------------------------------
module tb_fly_hit_scanner;

    localparam int N_FLY     = 17;
    localparam int SCORE_MAX = 9999;

    logic                 clk25 = 1'b0;
    logic                 reset_n;
    logic                 frame_tick;
    logic [10*N_FLY-1:0]  fly_x_flat;
    logic [10*N_FLY-1:0]  fly_y_flat;
    logic [N_FLY-1:0]     fly_alive_flat;
    logic [9:0]           bullet_x;
    logic [9:0]           bullet_y;
    logic                 bullet_active;
    logic                 scan_done;
    logic [13:0]          score;
    logic                 scan_overrun;

    logic [9:0] fx_a [N_FLY];
    logic [9:0] fy_a [N_FLY];
    logic       alive_a [N_FLY];

    int n_checks = 0;
    int n_fail   = 0;
    int exp_score = 0;

    fly_hit_scanner_if hit_bus ();

    fly_hit_scanner dut (
        .clk25          (clk25),
        .reset_n        (reset_n),
        .frame_tick     (frame_tick),
        .fly_x_flat     (fly_x_flat),
        .fly_y_flat     (fly_y_flat),
        .fly_alive_flat (fly_alive_flat),
        .bullet_x       (bullet_x),
        .bullet_y       (bullet_y),
        .bullet_active  (bullet_active),
        .hit            (hit_bus.master),
        .scan_done      (scan_done),
        .score          (score),
        .scan_overrun   (scan_overrun)
    );

    always #20 clk25 = ~clk25;

    always_comb begin
        fly_x_flat     = '0;
        fly_y_flat     = '0;
        fly_alive_flat = '0;
        for (int i = 0; i < N_FLY; i++) begin
            fly_x_flat[i*10 +: 10] = fx_a[i];
            fly_y_flat[i*10 +: 10] = fy_a[i];
            fly_alive_flat[i]      = alive_a[i];
        end
    end

    task automatic check(input string tag, input int unsigned actual, input int unsigned expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk25);
        #1;
    endtask

    // Raise frame_tick for one edge; returns 1 ns into cycle T+1.
    task automatic pulse_tick();
        @(negedge clk25);
        frame_tick = 1'b1;
        @(posedge clk25);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic clear_flies();
        for (int i = 0; i < N_FLY; i++) begin
            fx_a[i]    = '0;
            fy_a[i]    = '0;
            alive_a[i] = 1'b0;
        end
    endtask

    task automatic set_fly(input int i, input int x, input int y, input logic a);
        fx_a[i]    = 10'(x);
        fy_a[i]    = 10'(y);
        alive_a[i] = a;
    endtask

    task automatic set_bullet(input int x, input int y);
        bullet_x      = 10'(x);
        bullet_y      = 10'(y);
        bullet_active = 1'b1;
    endtask

    // Acknowledge in the current cycle X: effects at X+1, scan_done at X+2.
    task automatic ack_hit(input string tag);
        @(negedge clk25);
        hit_bus.hit_ack = 1'b1;
        @(posedge clk25);
        #1;
        hit_bus.hit_ack = 1'b0;
        if (exp_score < SCORE_MAX) exp_score++;
        check({tag, " consume"}, hit_bus.bullet_consume, 1);
        check({tag, " valid_clr"}, hit_bus.hit_valid, 0);
        check({tag, " score"}, score, exp_score);
        step(1);
        check({tag, " done"}, scan_done, 1);
        check({tag, " consume_1cyc"}, hit_bus.bullet_consume, 0);
    endtask

    // Full scan with exact timing: hit on k at T+2+k, or scan_done at T+N_FLY+2.
    task automatic scan_expect(input string tag, input bit exp_hit, input int exp_idx);
        bit seen;
        pulse_tick();
        if (exp_hit) begin
            step(exp_idx);
            check({tag, " early"}, hit_bus.hit_valid, 0);
            step(1);
            check({tag, " valid"}, hit_bus.hit_valid, 1);
            check({tag, " idx"}, hit_bus.hit_idx, exp_idx);
            ack_hit(tag);
        end else begin
            seen = 1'b0;
            repeat (N_FLY) begin
                step(1);
                seen |= hit_bus.hit_valid;
            end
            check({tag, " no_valid"}, seen, 0);
            check({tag, " done_early"}, scan_done, 0);
            step(1);
            check({tag, " done"}, scan_done, 1);
        end
    endtask

    initial begin
        bit stable;
        bit seen_done;
        bit seen_cons;

        reset_n         = 1'b0;
        frame_tick      = 1'b0;
        bullet_x        = '0;
        bullet_y        = '0;
        bullet_active   = 1'b0;
        hit_bus.hit_ack = 1'b0;
        clear_flies();

        step(3);
        check("rst valid", hit_bus.hit_valid, 0);
        check("rst idx", hit_bus.hit_idx, 0);
        check("rst consume", hit_bus.bullet_consume, 0);
        check("rst done", scan_done, 0);
        check("rst score", score, 0);
        check("rst overrun", scan_overrun, 0);
        @(negedge clk25);
        reset_n = 1'b1;
        step(2);

        // Basic hit, bullet moved and deactivated mid-scan.
        clear_flies();
        set_fly(3, 114, 40, 1'b1);
        set_bullet(120, 50);
        pulse_tick();                      // now T+1
        bullet_x      = 10'd600;
        bullet_y      = 10'd400;
        bullet_active = 1'b0;
        step(3);                           // T+4
        check("basic early", hit_bus.hit_valid, 0);
        step(1);                           // T+5
        check("basic valid", hit_bus.hit_valid, 1);
        check("basic idx", hit_bus.hit_idx, 3);
        step(2);                           // T+7
        check("basic hold", hit_bus.hit_valid, 1);
        ack_hit("basic");

        // Right/left edges of fly 0.
        clear_flies();
        set_fly(0, 100, 100, 1'b1);
        set_bullet(132, 100);
        scan_expect("bnd x132", 1'b0, 0);
        set_bullet(131, 100);
        scan_expect("bnd x131", 1'b1, 0);
        set_bullet(98, 100);
        scan_expect("bnd x98", 1'b0, 0);
        set_bullet(99, 100);
        scan_expect("bnd x99", 1'b1, 0);

        // Priority with a dead lower-index fly.
        clear_flies();
        set_fly(5, 200, 200, 1'b0);
        set_fly(6, 200, 200, 1'b1);
        set_bullet(210, 210);
        scan_expect("prio dead5", 1'b1, 6);
        set_fly(5, 200, 200, 1'b1);
        scan_expect("prio alive5", 1'b1, 5);

        // Inactive bullet: empty scan, scan_done at T+2.
        bullet_active = 1'b0;
        pulse_tick();
        check("empty done_early", scan_done, 0);
        step(1);
        check("empty done", scan_done, 1);
        check("empty valid", hit_bus.hit_valid, 0);
        check("empty consume", hit_bus.bullet_consume, 0);
        check("overrun clean", scan_overrun, 0);

        // Handshake hold with a second frame_tick during REPORT.
        clear_flies();
        set_fly(2, 300, 300, 1'b1);
        set_bullet(310, 310);
        pulse_tick();
        step(3);                           // T+4 = hit on k=2
        check("hold valid", hit_bus.hit_valid, 1);
        stable = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (c == 10) begin
                frame_tick = 1'b1;
                step(1);
                frame_tick = 1'b0;
            end else begin
                step(1);
            end
            if (hit_bus.hit_valid !== 1'b1 || hit_bus.hit_idx !== 5'd2 ||
                score !== 14'(exp_score))
                stable = 1'b0;
        end
        check("hold stable", stable, 1);
        check("hold overrun", scan_overrun, 1);
        check("hold score", score, exp_score);
        ack_hit("hold");

        // Saturation: ack held high so each scan completes in a few cycles.
        clear_flies();
        set_fly(0, 100, 100, 1'b1);
        set_bullet(100, 100);
        hit_bus.hit_ack = 1'b1;
        while (exp_score < SCORE_MAX) begin
            pulse_tick();
            step(3);
            exp_score++;
        end
        hit_bus.hit_ack = 1'b0;
        check("sat reach", score, SCORE_MAX);
        scan_expect("sat extra", 1'b1, 0);

        // Asynchronous reset mid-REPORT.
        pulse_tick();
        step(1);
        check("areset pre valid", hit_bus.hit_valid, 1);
        @(negedge clk25);
        #3 reset_n = 1'b0;
        #2;
        check("areset valid", hit_bus.hit_valid, 0);
        check("areset score", score, 0);
        check("areset overrun", scan_overrun, 0);
        #5 reset_n = 1'b1;
        exp_score = 0;
        seen_done = 1'b0;
        seen_cons = 1'b0;
        repeat (25) begin
            step(1);
            seen_done |= scan_done;
            seen_cons |= hit_bus.bullet_consume;
        end
        check("areset no_done", seen_done, 0);
        check("areset no_consume", seen_cons, 0);
        check("areset valid_after", hit_bus.hit_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
